// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared types and encodings for the hazard controller.
package pipeline_hazard_ctrl_pkg;
  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_MEM_WAIT} state_t;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W = 2'b01;
  localparam logic [1:0] FWD_M = 2'b10;
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// fwd_unit: operand bypass select for one execute-stage source register.
module fwd_unit
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic       reg_write_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_w,
  output logic [1:0] fwd
);
  // M is the younger producer, so it shadows W; x0 is never bypassed.
  assign fwd = (reg_write_m && rd_m != 5'd0 && rd_m == rs_e) ? FWD_M :
               (reg_write_w && rd_w != 5'd0 && rd_w == rs_e) ? FWD_W : FWD_RF;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/forward control for a 5-stage pipeline
// with a variable-latency data memory, post-reset flush and hazard counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int INIT_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [1:0]  ResultSrcE,
  input  logic        PCSrcE,
  input  logic [4:0]  RdM,
  input  logic        RegWriteM,
  input  logic        MemReqM,
  input  logic        MemReadyM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteW,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        MemTimeout,
  output logic [15:0] StallCnt,
  output logic [15:0] FlushCnt
);
  localparam logic [15:0] INIT_LAST = 16'(INIT_CYC - 1);
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYC);
  state_t state_q, state_d;
  logic [15:0] init_cnt_q, init_cnt_d, wait_cnt_q, wait_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic timeout_q, timeout_d;
  logic in_init, mem_stall, run_free, lw_stall, br_flush;
  fwd_unit u_fwd_a (
    .rs_e(Rs1E), .rd_m(RdM), .reg_write_m(RegWriteM),
    .rd_w(RdW), .reg_write_w(RegWriteW), .fwd(ForwardAE)
  );
  fwd_unit u_fwd_b (
    .rs_e(Rs2E), .rd_m(RdM), .reg_write_m(RegWriteM),
    .rd_w(RdW), .reg_write_w(RegWriteW), .fwd(ForwardBE)
  );
  always_comb begin
    in_init = state_q == ST_INIT;
    mem_stall = !MemReadyM && (state_q == ST_MEM_WAIT || (state_q == ST_RUN && MemReqM));
    run_free = state_q == ST_RUN && !mem_stall;
    lw_stall = ResultSrcE == RES_MEM && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
    br_flush = run_free && PCSrcE;
    // A taken branch squashes D, so holding it for the load-use would be pointless.
    StallF = in_init || mem_stall || (run_free && lw_stall);
    StallD = mem_stall || (run_free && lw_stall && !PCSrcE);
    StallE = mem_stall;
    StallM = mem_stall;
    FlushD = in_init || br_flush;
    FlushE = in_init || (run_free && (lw_stall || PCSrcE));
    FlushW = in_init || mem_stall;
    state_d = in_init ? (init_cnt_q == INIT_LAST ? ST_RUN : ST_INIT) :
              state_q == ST_RUN ? (mem_stall ? ST_MEM_WAIT : ST_RUN) :
              (MemReadyM ? ST_RUN : ST_MEM_WAIT);
    init_cnt_d = (in_init && init_cnt_q != INIT_LAST) ? init_cnt_q + 16'd1 : init_cnt_q;
    // The wait counter sits at zero throughout RUN, which clears it on every entry.
    wait_cnt_d = state_q != ST_MEM_WAIT ? 16'd0 :
                 (!MemReadyM && wait_cnt_q != TIMEOUT_LIM) ? wait_cnt_q + 16'd1 : wait_cnt_q;
    timeout_d = timeout_q || (state_q == ST_MEM_WAIT && !MemReadyM && wait_cnt_d == TIMEOUT_LIM);
    stall_cnt_d = (StallF && !in_init && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    flush_cnt_d = (br_flush && flush_cnt_q != 16'hFFFF) ? flush_cnt_q + 16'd1 : flush_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      init_cnt_q <= '0;
      wait_cnt_q <= '0;
      timeout_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      init_cnt_q <= init_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign MemTimeout = timeout_q;
  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: vector table, corner sequences and random traffic
// checked against a cycle-level model of the hazard rules.
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;
  localparam int TO = 255;
  localparam int IC = 2;
  typedef struct packed {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
    logic [1:0] ressrc;
    logic       pcsrc;
    logic [4:0] rdm;
    logic       regwm, memreq, memrdy;
    logic [4:0] rdw;
    logic       regww;
  } in_t;
  typedef struct packed {
    logic sf, sd, se, sm, fd, fe, fw;
    logic [1:0] fa, fb;
  } out_t;
  typedef struct {
    string name;
    in_t   i;
    out_t  o;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  in_t in;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
  logic [1:0] ForwardAE, ForwardBE;
  logic [15:0] StallCnt, FlushCnt;
  out_t dout;
  int n_chk = 0;
  int n_err = 0;
  int m_mode, m_init, m_wait, m_sc, m_fc;
  bit m_to;
  vec_t vecs[14];

  always #5 clk = ~clk;
  assign dout = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE, ForwardBE};

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(in.rs1d), .Rs2D(in.rs2d), .Rs1E(in.rs1e), .Rs2E(in.rs2e), .RdE(in.rde),
    .ResultSrcE(in.ressrc), .PCSrcE(in.pcsrc), .RdM(in.rdm), .RegWriteM(in.regwm),
    .MemReqM(in.memreq), .MemReadyM(in.memrdy), .RdW(in.rdw), .RegWriteW(in.regww),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MemTimeout(MemTimeout),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  // model modes: 0 = post-reset flush, 1 = running, 2 = waiting on memory
  function automatic logic [1:0] fwd_of(input logic [4:0] r, input in_t x);
    if (x.regwm && x.rdm != 0 && x.rdm == r) return 2'b10;
    if (x.regww && x.rdw != 0 && x.rdw == r) return 2'b01;
    return 2'b00;
  endfunction

  function automatic out_t model_out(input in_t x);
    out_t o;
    logic lw;
    o = '0;
    o.fa = fwd_of(x.rs1e, x);
    o.fb = fwd_of(x.rs2e, x);
    lw = x.ressrc == 2'b01 && x.rde != 0 && (x.rde == x.rs1d || x.rde == x.rs2d);
    if (m_mode == 0) begin
      o.sf = 1; o.fd = 1; o.fe = 1; o.fw = 1;
    end else if (!x.memrdy && (m_mode == 2 || x.memreq)) begin
      o.sf = 1; o.sd = 1; o.se = 1; o.sm = 1; o.fw = 1;
    end else if (m_mode == 1) begin
      o.sf = lw; o.sd = lw && !x.pcsrc; o.fd = x.pcsrc; o.fe = lw || x.pcsrc;
    end
    return o;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_init = 0; m_wait = 0; m_to = 0; m_sc = 0; m_fc = 0;
  endtask

  task automatic step();
    out_t e;
    e = model_out(in);
    if (rst_n) begin
      if (m_mode != 0 && e.sf && m_sc < 65535) m_sc++;
      if (m_mode == 1 && e.fd && m_fc < 65535) m_fc++;
      case (m_mode)
        0: begin m_init++; if (m_init == IC) m_mode = 1; end
        1: if (in.memreq && !in.memrdy) begin m_mode = 2; m_wait = 0; end
        default: if (in.memrdy) m_mode = 1;
                 else begin if (m_wait < TO) m_wait++; if (m_wait == TO) m_to = 1; end
      endcase
    end
    @(posedge clk);
  endtask

  task automatic drive(input in_t x);
    @(negedge clk);
    in = x;
    #1;
  endtask

  task automatic chk_all(input string nm);
    logic [43:0] g, w;
    out_t e;
    e = model_out(in);
    g = {dout, MemTimeout, StallCnt, FlushCnt};
    w = {e, m_to, 16'(m_sc), 16'(m_fc)};
    n_chk++;
    if (g !== w) begin
      n_err++;
      $display("FAIL %s: outs/timeout/stallcnt/flushcnt got %h want %h", nm, g, w);
    end
  endtask

  task automatic expect_eq(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic rand_cycles(input int n);
    in_t x;
    for (int k = 0; k < n; k++) begin
      x = '0;
      x.rs1d = 5'($urandom_range(0, 7)); x.rs2d = 5'($urandom_range(0, 7));
      x.rs1e = 5'($urandom_range(0, 7)); x.rs2e = 5'($urandom_range(0, 7));
      x.rde = 5'($urandom_range(0, 7)); x.ressrc = 2'($urandom_range(0, 3));
      x.pcsrc = $urandom_range(0, 3) == 0; x.rdm = 5'($urandom_range(0, 7));
      x.regwm = 1'($urandom_range(0, 1)); x.memreq = $urandom_range(0, 3) == 0;
      x.memrdy = $urandom_range(0, 2) != 0; x.rdw = 5'($urandom_range(0, 7));
      x.regww = 1'($urandom_range(0, 1));
      drive(x);
      chk_all("random");
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int f0, s0;
    in_t x;
    vecs[0]  = '{name: "idle", i: '0, o: '0};
    vecs[1]  = '{name: "fwd_m_a", i: '{rdm: 5'd5, regwm: 1'b1, rdw: 5'd5, regww: 1'b1, rs1e: 5'd5, default: '0}, o: '{fa: FWD_M, default: '0}};
    vecs[2]  = '{name: "fwd_w_a", i: '{rdm: 5'd0, regwm: 1'b1, rdw: 5'd5, regww: 1'b1, rs1e: 5'd5, default: '0}, o: '{fa: FWD_W, default: '0}};
    vecs[3]  = '{name: "fwd_w_b", i: '{rs2e: 5'd9, rdw: 5'd9, regww: 1'b1, default: '0}, o: '{fb: FWD_W, default: '0}};
    vecs[4]  = '{name: "fwd_m_both", i: '{rs1e: 5'd9, rs2e: 5'd9, rdm: 5'd9, regwm: 1'b1, rdw: 5'd9, regww: 1'b1, default: '0}, o: '{fa: FWD_M, fb: FWD_M, default: '0}};
    vecs[5]  = '{name: "fwd_x0", i: '{regwm: 1'b1, regww: 1'b1, default: '0}, o: '0};
    vecs[6]  = '{name: "fwd_nowrite", i: '{rs1e: 5'd3, rdm: 5'd3, rdw: 5'd3, default: '0}, o: '0};
    vecs[7]  = '{name: "lw_rs2", i: '{ressrc: RES_MEM, rde: 5'd7, rs2d: 5'd7, default: '0}, o: '{sf: 1'b1, sd: 1'b1, fe: 1'b1, default: '0}};
    vecs[8]  = '{name: "lw_rs1", i: '{ressrc: RES_MEM, rde: 5'd12, rs1d: 5'd12, default: '0}, o: '{sf: 1'b1, sd: 1'b1, fe: 1'b1, default: '0}};
    vecs[9]  = '{name: "lw_branch", i: '{ressrc: RES_MEM, rde: 5'd7, rs2d: 5'd7, pcsrc: 1'b1, default: '0}, o: '{sf: 1'b1, fd: 1'b1, fe: 1'b1, default: '0}};
    vecs[10] = '{name: "lw_rd0", i: '{ressrc: RES_MEM, default: '0}, o: '0};
    vecs[11] = '{name: "alu_no_stall", i: '{ressrc: RES_ALU, rde: 5'd7, rs1d: 5'd7, default: '0}, o: '0};
    vecs[12] = '{name: "branch", i: '{pcsrc: 1'b1, default: '0}, o: '{fd: 1'b1, fe: 1'b1, default: '0}};
    vecs[13] = '{name: "memready_lw", i: '{memreq: 1'b1, memrdy: 1'b1, ressrc: RES_MEM, rde: 5'd4, rs1d: 5'd4, default: '0}, o: '{sf: 1'b1, sd: 1'b1, fe: 1'b1, default: '0}};
    in = '0;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      drive('0);
      chk_all("reset_hold");
      expect_eq("reset_outs", 32'(dout), 32'b1000111_0000);
      step();
    end
    #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive('0);
      chk_all("init_seq");
      expect_eq("init_stallf", 32'(StallF), 32'(k < 2));
      step();
    end
    foreach (vecs[k]) begin
      drive(vecs[k].i);
      chk_all(vecs[k].name);
      expect_eq(vecs[k].name, 32'(dout), 32'(vecs[k].o));
      step();
    end
    f0 = FlushCnt;
    drive(vecs[9].i);
    step();
    drive('0);
    expect_eq("flushcnt_inc", 32'(FlushCnt), 32'(f0 + 1));
    step();
    s0 = StallCnt;
    for (int k = 0; k < 3; k++) begin
      drive('{memreq: 1'b1, pcsrc: 1'(k == 2), ressrc: RES_MEM, rde: 5'd3, rs1d: 5'd3, default: '0});
      chk_all("memwait");
      expect_eq("memwait_stalls", 32'({StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE}), 32'b1111100);
      step();
    end
    drive('{memreq: 1'b1, memrdy: 1'b1, pcsrc: 1'b1, default: '0});
    chk_all("mem_ready");
    expect_eq("mem_ready_release", 32'({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}), 32'b0);
    expect_eq("mem_stallcnt", 32'(StallCnt), 32'(s0 + 3));
    step();
    drive('{pcsrc: 1'b1, default: '0});
    chk_all("branch_after_wait");
    expect_eq("branch_after_wait_fd", 32'(FlushD), 32'b1);
    step();
    rand_cycles(400);
    x = '{memrdy: 1'b1, default: '0};
    drive(x);
    chk_all("pre_timeout");
    step();
    for (int k = 0; k < 300; k++) begin
      drive('{memreq: 1'b1, default: '0});
      chk_all("timeout_wait");
      if (k == 255) expect_eq("timeout_not_yet", 32'(MemTimeout), 32'b0);
      if (k == 256) expect_eq("timeout_set", 32'(MemTimeout), 32'b1);
      step();
    end
    drive('{memrdy: 1'b1, default: '0});
    chk_all("timeout_release");
    step();
    drive('0);
    expect_eq("timeout_sticky", 32'(MemTimeout), 32'b1);
    step();
    drive('{memreq: 1'b1, default: '0});
    step();
    drive('{memreq: 1'b1, default: '0});
    chk_all("pre_reset_wait");
    step();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_all("reset_midwait");
    expect_eq("reset_midwait_cnts", {15'b0, MemTimeout, StallCnt}, 32'b0);
    expect_eq("reset_midwait_flush", 32'(FlushCnt), 32'b0);
    expect_eq("reset_midwait_outs", 32'({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}), 32'b1000111);
    step();
    #2 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive('{memreq: 1'b1, default: '0});
      chk_all("after_reset_wait");
      step();
    end
    rand_cycles(100);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
